// File: rtl/ui_bus_arbiter.sv
// Two-master round-robin arbiter in front of the board UI block (KEY/SW/LEDR/HEX).
// Define UIARB_ERR_EN to add per-master error outputs and block writes to the read-only inputs.
module ui_bus_arbiter #(
  parameter int               DBITS     = 32,
  parameter logic [DBITS-1:0] ADDR_HEX  = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY  = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW   = 32'hF0000014
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [DBITS-1:0] m0_addr,
  input  logic [DBITS-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [DBITS-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [DBITS-1:0] m1_addr,
  input  logic [DBITS-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [DBITS-1:0] m1_rdata,
`ifdef UIARB_ERR_EN
  output logic             m0_err,
  output logic             m1_err,
`endif
  output logic             ui_wrtEn,
  output logic [1:0]       ui_dev,
  output logic [DBITS-1:0] ui_wdata,
  input  logic [DBITS-1:0] ui_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state_q;
  logic       rr_q;      // 1 = m1 favoured on a tie
  logic       win_q;     // 1 = m1 owns the current access
  logic       mapped_q;

  logic             win_m1;
  logic             sel_we;
  logic [DBITS-1:0] sel_addr;
  logic [DBITS-1:0] sel_wdata;
  logic             mapped_d;
  logic [1:0]       dev_d;
  logic             wen_d;

  // Byte-lane bits take no part in register selection.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{sel_addr[1:0]};

  assign win_m1    = m1_req && (!m0_req || rr_q);
  assign sel_we    = win_m1 ? m1_we    : m0_we;
  assign sel_addr  = win_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = win_m1 ? m1_wdata : m0_wdata;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    mapped_d = 1'b1;
    dev_d    = 2'd0;
    if (sel_addr[DBITS-1:2] == ADDR_KEY[DBITS-1:2])       dev_d = 2'd0;
    else if (sel_addr[DBITS-1:2] == ADDR_SW[DBITS-1:2])   dev_d = 2'd1;
    else if (sel_addr[DBITS-1:2] == ADDR_LEDR[DBITS-1:2]) dev_d = 2'd2;
    else if (sel_addr[DBITS-1:2] == ADDR_HEX[DBITS-1:2])  dev_d = 2'd3;
    else                                                  mapped_d = 1'b0;
  end

`ifdef UIARB_ERR_EN
  logic ro_d;
  logic err_d;
  logic err_q;
  assign ro_d  = mapped_d && (dev_d[1] == 1'b0);
  assign wen_d = sel_we && mapped_d && !ro_d;
  assign err_d = !mapped_d || (sel_we && ro_d);
`else
  assign wen_d = sel_we && mapped_d;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the read-data holding registers are architecturally visible, so they are reset too.
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      win_q     <= 1'b0;
      mapped_q  <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      ui_wrtEn  <= 1'b0;
      ui_dev    <= 2'd0;
      ui_wdata  <= '0;
`ifdef UIARB_ERR_EN
      err_q     <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q  <= ACCESS;
            win_q    <= win_m1;
            rr_q     <= ~win_m1;
            mapped_q <= mapped_d;
            m0_gnt   <= ~win_m1;
            m1_gnt   <= win_m1;
            ui_wrtEn <= wen_d;
            ui_dev   <= dev_d;
            ui_wdata <= sel_wdata;
`ifdef UIARB_ERR_EN
            err_q    <= err_d;
`endif
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          m0_gnt   <= 1'b0;
          m1_gnt   <= 1'b0;
          ui_wrtEn <= 1'b0;
          ui_dev   <= 2'd0;
          ui_wdata <= '0;
          if (win_q) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= mapped_q ? ui_rdata : '0;
`ifdef UIARB_ERR_EN
            m1_err    <= err_q;
`endif
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= mapped_q ? ui_rdata : '0;
`ifdef UIARB_ERR_EN
            m0_err    <= err_q;
`endif
          end
        end
        RESP: begin
          state_q   <= IDLE;
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
`ifdef UIARB_ERR_EN
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ui_bus_arbiter.sv
// Directed self-checking bench for ui_bus_arbiter; inputs change and outputs are sampled on the negedge.
module tb_ui_bus_arbiter;

  localparam logic [31:0] ADDR_HEX  = 32'hF0000000;
  localparam logic [31:0] ADDR_LEDR = 32'hF0000004;
  localparam logic [31:0] ADDR_KEY  = 32'hF0000010;
  localparam logic [31:0] ADDR_SW   = 32'hF0000014;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ui_wrtEn;
  logic [1:0]  ui_dev;
  logic [31:0] ui_wdata, ui_rdata;
  logic [31:0] key_val, sw_val;
  logic [104:0] all_out;
`ifdef UIARB_ERR_EN
  logic        m0_err, m1_err;
`endif

  int checks = 0;
  int errors = 0;

  ui_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef UIARB_ERR_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .ui_wrtEn(ui_wrtEn), .ui_dev(ui_dev), .ui_wdata(ui_wdata), .ui_rdata(ui_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UI controller model: combinational read mux on the device select.
  always_comb begin
    case (ui_dev)
      2'd0:    ui_rdata = key_val;
      2'd1:    ui_rdata = sw_val;
      2'd2:    ui_rdata = 32'h0000_0111;
      default: ui_rdata = 32'h0000_0333;
    endcase
  end

`ifdef UIARB_ERR_EN
  assign all_out = {m0_err, m1_err, m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                    ui_wrtEn, ui_dev, ui_wdata};
`else
  assign all_out = {2'b00, m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                    ui_wrtEn, ui_dev, ui_wdata};
`endif

  task automatic pulse_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", all_out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL idle_after_reset got %h exp 0", all_out);
    end
  endtask

  task automatic test_write_ledr;
    m0_we = 1'b1; m0_addr = ADDR_LEDR; m0_wdata = 32'h2A5; m0_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, ui_wrtEn, ui_dev, ui_wdata} !== {1'b1, 1'b0, 1'b1, 2'd2, 32'h2A5}) begin
      errors++;
      $display("FAIL ledr_access got gnt=%b%b wen=%b dev=%0d wd=%h exp 10 1 2 2a5",
               m0_gnt, m1_gnt, ui_wrtEn, ui_dev, ui_wdata);
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m0_gnt, ui_wrtEn, ui_dev} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL ledr_resp got rv=%b gnt=%b wen=%b dev=%0d exp 1 0 0 0",
               m0_rvalid, m0_gnt, ui_wrtEn, ui_dev);
    end
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL ledr_rvalid_single got %b exp 0", m0_rvalid);
    end
  endtask

  task automatic test_read_sw;
    sw_val = 32'h3FF;
    m1_we = 1'b0; m1_addr = ADDR_SW; m1_wdata = 32'h0; m1_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt, ui_wrtEn, ui_dev} !== {1'b1, 1'b0, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL sw_access got gnt1=%b gnt0=%b wen=%b dev=%0d exp 1 0 0 1",
               m1_gnt, m0_gnt, ui_wrtEn, ui_dev);
    end
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m0_rvalid, ui_wrtEn, m1_rdata} !== {1'b1, 1'b0, 1'b0, 32'h3FF}) begin
      errors++;
      $display("FAIL sw_resp got rv1=%b rv0=%b wen=%b rdata=%h exp 1 0 0 3ff",
               m1_rvalid, m0_rvalid, ui_wrtEn, m1_rdata);
    end
`ifdef UIARB_ERR_EN
    checks++;
    if (m1_err !== 1'b0) begin
      errors++; $display("FAIL sw_err got %b exp 0", m1_err);
    end
`endif
    sw_val = 32'h0;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m1_rdata} !== {1'b0, 32'h3FF}) begin
      errors++; $display("FAIL sw_rdata_hold got rv=%b rdata=%h exp 0 3ff", m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_t [1:9];
    logic [3:0] got;
    exp_t = '{4'b1000, 4'b0010, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b1000, 4'b0010, 4'b0000};
    pulse_reset();
    m0_we = 1'b1; m0_addr = ADDR_HEX; m0_wdata = 32'h1; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = ADDR_SW;  m1_wdata = 32'h0; m1_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      got = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid};
      checks++;
      if (got !== exp_t[i]) begin
        errors++;
        $display("FAIL rr_cycle%0d got g0g1r0r1=%b exp %b", i, got, exp_t[i]);
      end
      if (i == 7) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
    end
  endtask

  task automatic test_unmapped;
    key_val = 32'hF;
    m0_we = 1'b0; m0_addr = 32'hF0000020; m0_wdata = 32'h0; m0_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0_gnt, ui_wrtEn, ui_dev} !== {1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL unmapped_access got gnt=%b wen=%b dev=%0d exp 1 0 0", m0_gnt, ui_wrtEn, ui_dev);
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL unmapped_resp got rv=%b rdata=%h exp 1 0", m0_rvalid, m0_rdata);
    end
`ifdef UIARB_ERR_EN
    checks++;
    if (m0_err !== 1'b1) begin
      errors++; $display("FAIL unmapped_err got %b exp 1", m0_err);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_write_key;
    m1_we = 1'b1; m1_addr = ADDR_KEY; m1_wdata = 32'h7; m1_req = 1'b1;
    @(negedge clk);
`ifdef UIARB_ERR_EN
    checks++;
    if ({m1_gnt, ui_wrtEn, ui_dev} !== {1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL key_write_access got gnt=%b wen=%b dev=%0d exp 1 0 0", m1_gnt, ui_wrtEn, ui_dev);
    end
`else
    checks++;
    if ({m1_gnt, ui_wrtEn, ui_dev, ui_wdata} !== {1'b1, 1'b1, 2'd0, 32'h7}) begin
      errors++;
      $display("FAIL key_write_access got gnt=%b wen=%b dev=%0d wd=%h exp 1 1 0 7",
               m1_gnt, ui_wrtEn, ui_dev, ui_wdata);
    end
`endif
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, ui_wrtEn} !== 2'b10) begin
      errors++; $display("FAIL key_write_resp got rv=%b wen=%b exp 1 0", m1_rvalid, ui_wrtEn);
    end
`ifdef UIARB_ERR_EN
    checks++;
    if (m1_err !== 1'b1) begin
      errors++; $display("FAIL key_write_err got %b exp 1", m1_err);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    m1_we = 1'b1; m1_addr = ADDR_HEX; m1_wdata = 32'h55; m1_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({m1_gnt, ui_wrtEn, ui_dev} !== {1'b1, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL hex_access got gnt=%b wen=%b dev=%0d exp 1 1 3", m1_gnt, ui_wrtEn, ui_dev);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL async_reset got %h exp 0", all_out);
    end
    m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m1_rvalid, ui_wrtEn} !== 2'b00) begin
        errors++;
        $display("FAIL abort_cycle%0d got rv1=%b wen=%b exp 0 0", i, m1_rvalid, ui_wrtEn);
      end
    end
    m0_we = 1'b0; m0_addr = ADDR_KEY; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = ADDR_SW;  m1_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL post_reset_winner got %b%b exp 10", m0_gnt, m1_gnt);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    key_val = 32'h0; sw_val = 32'h0;
    test_reset();
    test_write_ledr();
    test_read_sw();
    test_round_robin();
    test_unmapped();
    test_write_key();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
